fb_stream_loader: RTL and testbench

//  Frame-mode framebuffer writer: takes a raw byte stream from the ctrl rx path (uart_rx/spi_slave

---
 rtl/fb_loader_pkg.sv | 16 +
 rtl/fb_stream_loader_byte_fifo.sv | 69 ++++++
 rtl/fb_stream_loader.sv | 176 +++++++++++++++++
 tb/tb_fb_stream_loader.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_loader_pkg.sv
// Shared types and helpers for the framebuffer stream loader.
package fb_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3
    } loader_state_t;

    // Number of bytes that make up one complete frame.
    function automatic int frame_bytes(input int w, input int h, input int bpp);
        return w * h * bpp;
    endfunction

endpackage

// File: rtl/fb_stream_loader_byte_fifo.sv
// Small byte FIFO with registered read data. A push into a full FIFO is
// accepted when a pop happens in the same cycle; flush empties it at once.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rstb,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = dout_reg;
    assign pop_ok  = pop && !flush && !empty;
    assign push_ok = push && !flush && (!full || pop_ok);

    // Storage array; no reset so it can map onto distributed/block memory.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers, occupancy and registered read data.
    always_ff @(posedge clk_in or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                dout_reg   <= mem[rd_ptr_reg];
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fb_stream_loader.sv
// Frame-mode framebuffer writer: buffers an rx byte stream and writes it
// sequentially into a RAM port, tolerating grant backpressure, flagging
// dropped bytes and aborting a stalled frame after an idle timeout.
module fb_stream_loader
    import fb_loader_pkg::*;
#(
    parameter int PIXEL_WIDTH     = 64,
    parameter int PIXEL_HEIGHT    = 32,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int FIFO_DEPTH      = 4,
    parameter int TIMEOUT_TICKS   = 4096,
    parameter int BYTE_SWAP       = 0,
    localparam int FRAME_BYTES    = frame_bytes(PIXEL_WIDTH, PIXEL_HEIGHT, BYTES_PER_PIXEL),
    localparam int AW             = $clog2(FRAME_BYTES)
) (
    input  logic          clk_in,
    input  logic          rstb,
    input  logic          frame_start,
    input  logic [7:0]    data_rx,
    input  logic          data_valid,
    input  logic          ram_grant,
    output logic [7:0]    ram_data_out,
    output logic [AW-1:0] ram_address,
    output logic          ram_write_enable,
    output logic          ram_clk_enable,
    output logic          busy,
    output logic          frame_done,
    output logic          overflow,
    output logic          timeout
);

    localparam int FPW = $clog2(FIFO_DEPTH);
    localparam int TW  = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
    localparam logic [AW-1:0] SWAP_MASK = (BYTE_SWAP != 0) ? AW'(1) : '0;

    loader_state_t state_reg, state_next;
    logic [AW:0]   push_count_reg;
    logic [AW:0]   wr_count_reg;
    logic [TW-1:0] idle_reg;
    logic          overflow_reg;
    logic          timeout_reg;
    logic          we_reg;
    logic [AW-1:0] addr_reg;

    logic          fifo_full;
    logic          fifo_empty;
    logic [FPW:0]  fifo_count;
    logic [7:0]    fifo_dout;

    logic          loading;
    logic          writing;
    logic          timeout_hit;
    logic          flush;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          overflow_set;

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in (clk_in),
        .rstb   (rstb),
        .flush  (flush),
        .push   (push_ok),
        .din    (data_rx),
        .pop    (pop),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Datapath qualifiers: a restart or abort cycle flushes and suppresses any new pop.
    always_comb begin
        loading      = (state_reg == LOAD) && !frame_start;
        writing      = ((state_reg == LOAD) || (state_reg == DRAIN)) && !frame_start;
        timeout_hit  = (TIMEOUT_TICKS != 0) && loading && !data_valid &&
                       (idle_reg == TW'(TIMEOUT_TICKS - 1));
        flush        = frame_start || timeout_hit;
        pop          = writing && !timeout_hit && !fifo_empty && ram_grant;
        push_req     = loading && data_valid;
        push_ok      = push_req && (!fifo_full || pop);
        overflow_set = push_req && fifo_full && !pop;
    end

    // Next-state logic; frame_start restarts the frame from any state.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (frame_start) state_next = LOAD;
            end
            LOAD: begin
                if (frame_start) begin
                    state_next = LOAD;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end else if (push_ok && (push_count_reg == (AW+1)'(FRAME_BYTES - 1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (frame_start) begin
                    state_next = LOAD;
                end else if ((wr_count_reg == (AW+1)'(FRAME_BYTES)) && (fifo_count == '0)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = frame_start ? LOAD : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or negedge rstb) begin
        if (!rstb) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Frame counters, idle timer and sticky status flags.
    always_ff @(posedge clk_in or negedge rstb) begin
        if (!rstb) begin
            push_count_reg <= '0;
            wr_count_reg   <= '0;
            idle_reg       <= '0;
            overflow_reg   <= 1'b0;
            timeout_reg    <= 1'b0;
        end else if (frame_start) begin
            push_count_reg <= '0;
            wr_count_reg   <= '0;
            idle_reg       <= '0;
            overflow_reg   <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            if (push_ok)      push_count_reg <= push_count_reg + 1'b1;
            if (pop)          wr_count_reg   <= wr_count_reg + 1'b1;
            if (overflow_set) overflow_reg   <= 1'b1;
            if (timeout_hit)  timeout_reg    <= 1'b1;
            if (state_reg == LOAD && !data_valid) begin
                idle_reg <= idle_reg + 1'b1;
            end else begin
                idle_reg <= '0;
            end
        end
    end

    // RAM write strobe and address, registered one cycle after the pop.
    always_ff @(posedge clk_in or negedge rstb) begin
        if (!rstb) begin
            we_reg   <= 1'b0;
            addr_reg <= '0;
        end else begin
            we_reg <= pop;
            if (pop) begin
                addr_reg <= wr_count_reg[AW-1:0] ^ SWAP_MASK;
            end
        end
    end

    assign ram_data_out     = fifo_dout;
    assign ram_address      = addr_reg;
    assign ram_write_enable = we_reg;
    assign ram_clk_enable   = we_reg;
    assign busy             = (state_reg != IDLE);
    assign frame_done       = (state_reg == DONE);
    assign overflow         = overflow_reg;
    assign timeout          = timeout_reg;

endmodule

// File: tb/tb_fb_stream_loader.sv
// Scoreboard bench for fb_stream_loader: stimulus pushes expected RAM writes
// into a queue, per-DUT monitors pop and compare on every write strobe.
module tb_fb_stream_loader;

    localparam int AW = 4;   // 4x2 pixels, 2 bytes each -> 16 bytes

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic clk_in = 1'b0;
    logic rstb;
    always #5 clk_in = ~clk_in;

    // DUT A: straight addressing, timeout of 8 idle cycles
    logic          a_frame_start, a_data_valid, a_grant_level, a_ram_grant;
    logic [7:0]    a_data_rx, a_ram_data_out;
    logic [AW-1:0] a_ram_address;
    logic          a_we, a_ce, a_busy, a_frame_done, a_overflow, a_timeout;

    // DUT B: byte-swapped addressing
    logic          b_frame_start, b_data_valid, b_ram_grant;
    logic [7:0]    b_data_rx, b_ram_data_out;
    logic [AW-1:0] b_ram_address;
    logic          b_we, b_ce, b_busy, b_frame_done, b_overflow, b_timeout;

    fb_stream_loader #(
        .PIXEL_WIDTH(4), .PIXEL_HEIGHT(2), .BYTES_PER_PIXEL(2),
        .FIFO_DEPTH(4), .TIMEOUT_TICKS(8), .BYTE_SWAP(0)
    ) dut_a (
        .clk_in(clk_in), .rstb(rstb), .frame_start(a_frame_start),
        .data_rx(a_data_rx), .data_valid(a_data_valid), .ram_grant(a_ram_grant),
        .ram_data_out(a_ram_data_out), .ram_address(a_ram_address),
        .ram_write_enable(a_we), .ram_clk_enable(a_ce), .busy(a_busy),
        .frame_done(a_frame_done), .overflow(a_overflow), .timeout(a_timeout)
    );

    fb_stream_loader #(
        .PIXEL_WIDTH(4), .PIXEL_HEIGHT(2), .BYTES_PER_PIXEL(2),
        .FIFO_DEPTH(4), .TIMEOUT_TICKS(8), .BYTE_SWAP(1)
    ) dut_b (
        .clk_in(clk_in), .rstb(rstb), .frame_start(b_frame_start),
        .data_rx(b_data_rx), .data_valid(b_data_valid), .ram_grant(b_ram_grant),
        .ram_data_out(b_ram_data_out), .ram_address(b_ram_address),
        .ram_write_enable(b_we), .ram_clk_enable(b_ce), .busy(b_busy),
        .frame_done(b_frame_done), .overflow(b_overflow), .timeout(b_timeout)
    );

    wr_t exp_a[$];
    wr_t exp_b[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  done_a      = 0;
    int  done_b      = 0;
    int  a_next      = 0;   // model: index of the next frame byte for A
    int  b_next      = 0;

    // Grant shaping for A: level, or one cycle in three
    logic grant_toggle_mode = 1'b0;
    int   grant_phase       = 0;
    logic grant_toggle      = 1'b0;
    assign a_ram_grant = grant_toggle_mode ? grant_toggle : a_grant_level;

    always @(negedge clk_in) begin
        grant_phase  <= (grant_phase + 1) % 3;
        grant_toggle <= (grant_phase == 2);
    end

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end else begin
            $display("ok   %s = 0x%0h", name, actual);
        end
    endtask

    // Monitor A: every write strobe must match the head of the scoreboard
    always @(negedge clk_in) begin : mon_a
        wr_t e;
        if (rstb) begin
            if (a_we) begin
                if (exp_a.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL a_unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                             a_ram_address, a_ram_data_out);
                end else begin
                    e = exp_a.pop_front();
                    vectors++;
                    if (a_ram_address !== e.addr || a_ram_data_out !== e.data || a_ce !== 1'b1) begin
                        miscompares++;
                        $display("FAIL a_write: addr 0x%0h data 0x%0h ce %0b, expected addr 0x%0h data 0x%0h ce 1",
                                 a_ram_address, a_ram_data_out, a_ce, e.addr, e.data);
                    end else begin
                        $display("wr a addr 0x%0h data 0x%02h", a_ram_address, a_ram_data_out);
                    end
                end
            end
            if (a_frame_done) done_a++;
        end
    end

    // Monitor B
    always @(negedge clk_in) begin : mon_b
        wr_t e;
        if (rstb) begin
            if (b_we) begin
                if (exp_b.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL b_unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                             b_ram_address, b_ram_data_out);
                end else begin
                    e = exp_b.pop_front();
                    vectors++;
                    if (b_ram_address !== e.addr || b_ram_data_out !== e.data || b_ce !== 1'b1) begin
                        miscompares++;
                        $display("FAIL b_write: addr 0x%0h data 0x%0h ce %0b, expected addr 0x%0h data 0x%0h ce 1",
                                 b_ram_address, b_ram_data_out, b_ce, e.addr, e.data);
                    end else begin
                        $display("wr b addr 0x%0h data 0x%02h", b_ram_address, b_ram_data_out);
                    end
                end
            end
            if (b_frame_done) done_b++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // All drive tasks are entered and left on a falling edge.
    task automatic a_start();
        a_frame_start = 1'b1;
        a_next        = 0;
        @(negedge clk_in);
        a_frame_start = 1'b0;
    endtask

    task automatic b_start();
        b_frame_start = 1'b1;
        b_next        = 0;
        @(negedge clk_in);
        b_frame_start = 1'b0;
    endtask

    // One byte on A; 'accept' says whether the model expects it to be kept.
    task automatic a_byte(input logic [7:0] d, input bit accept, input int gap);
        wr_t e;
        a_data_rx    = d;
        a_data_valid = 1'b1;
        if (accept) begin
            e.addr = AW'(a_next);
            e.data = d;
            exp_a.push_back(e);
            a_next++;
        end
        @(negedge clk_in);
        a_data_valid = 1'b0;
        repeat (gap) @(negedge clk_in);
    endtask

    // Swapped addressing: byte k of the frame lands at address k^1.
    task automatic b_byte(input logic [7:0] d);
        wr_t e;
        b_data_rx    = d;
        b_data_valid = 1'b1;
        e.addr = AW'(b_next ^ 1);
        e.data = d;
        exp_b.push_back(e);
        b_next++;
        @(negedge clk_in);
        b_data_valid = 1'b0;
    endtask

    task automatic wait_drain_a(input string name);
        int n = 0;
        while (exp_a.size() != 0 && n < 300) begin
            @(negedge clk_in);
            n++;
        end
        tick(1);
        check(name, exp_a.size(), 0);
    endtask

    task automatic wait_drain_b(input string name);
        int n = 0;
        while (exp_b.size() != 0 && n < 300) begin
            @(negedge clk_in);
            n++;
        end
        tick(1);
        check(name, exp_b.size(), 0);
    endtask

    // A full frame of random bytes with random gaps, grant held high
    task automatic a_random_frame(input int max_gap);
        a_start();
        for (int i = 0; i < 16; i++) begin
            a_byte(8'($urandom_range(0, 255)), 1'b1, int'($urandom_range(0, max_gap)));
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int done_before;
        rstb          = 1'b0;
        a_frame_start = 1'b0; a_data_valid = 1'b0; a_data_rx = '0; a_grant_level = 1'b1;
        b_frame_start = 1'b0; b_data_valid = 1'b0; b_data_rx = '0; b_ram_grant   = 1'b1;
        tick(3);

        // Reset state
        check("rst_we",       a_we,           0);
        check("rst_ce",       a_ce,           0);
        check("rst_addr",     a_ram_address,  0);
        check("rst_data",     a_ram_data_out, 0);
        check("rst_busy",     a_busy,         0);
        check("rst_done",     a_frame_done,   0);
        check("rst_overflow", a_overflow,     0);
        check("rst_timeout",  a_timeout,      0);
        rstb = 1'b1;
        tick(2);

        // Data before any frame_start is ignored (a write would be unexpected)
        a_byte(8'h77, 1'b0, 3);
        check("idle_busy", a_busy, 0);

        // 1: 16 back-to-back bytes, data = address
        a_start();
        check("t1_busy", a_busy, 1);
        for (int i = 0; i < 16; i++) a_byte(8'(i), 1'b1, 0);
        wait_drain_a("t1_all_written");
        tick(4);
        check("t1_frame_done", done_a, 1);
        check("t1_overflow",   a_overflow, 0);
        check("t1_busy_after", a_busy, 0);

        // 2: grant 1-of-3, bytes every 4th cycle
        grant_toggle_mode = 1'b1;
        a_start();
        for (int i = 0; i < 16; i++) a_byte(8'($urandom_range(0, 255)), 1'b1, 3);
        wait_drain_a("t2_all_written");
        tick(4);
        grant_toggle_mode = 1'b0;
        check("t2_frame_done", done_a, 2);
        check("t2_overflow",   a_overflow, 0);

        // Randomized frames with random inter-byte gaps
        for (int f = 0; f < 3; f++) begin
            a_random_frame(5);
            wait_drain_a("rnd_all_written");
            tick(4);
            check("rnd_frame_done", done_a, 3 + f);
            check("rnd_overflow",   a_overflow, 0);
        end

        // 3: grant low, six bytes -> last two dropped
        a_grant_level = 1'b0;
        a_start();
        for (int i = 0; i < 6; i++) a_byte(8'(8'h30 + i), (i < 4), 0);
        check("t3_no_writes_yet", exp_a.size(), 4);
        a_grant_level = 1'b1;
        check("t3_overflow", a_overflow, 1);
        wait_drain_a("t3_four_written");
        tick(10);
        check("t3_timeout",    a_timeout, 1);
        check("t3_frame_done", done_a, 5);

        // 4: three bytes then silence -> timeout after 8 idle cycles
        a_start();
        check("t4_flags_cleared", a_overflow | a_timeout, 0);
        for (int i = 0; i < 3; i++) a_byte(8'(8'hC0 + i), 1'b1, 0);
        tick(5);
        check("t4_timeout_early", a_timeout, 0);
        check("t4_busy_early",    a_busy, 1);
        tick(4);
        check("t4_timeout",    a_timeout, 1);
        check("t4_busy",       a_busy, 0);
        check("t4_writes",     exp_a.size(), 0);
        check("t4_frame_done", done_a, 5);

        // 5: byte swap on DUT B
        b_start();
        b_byte(8'hA0);
        b_byte(8'hA1);
        wait_drain_b("t5_swapped_written");
        check("t5_frame_done", done_b, 0);

        // 6a: restart after 5 bytes
        a_start();
        for (int i = 0; i < 5; i++) a_byte(8'($urandom_range(0, 255)), 1'b1, 0);
        wait_drain_a("t6_partial_written");
        a_start();
        for (int i = 0; i < 16; i++) a_byte(8'($urandom_range(0, 255)), 1'b1, 0);
        wait_drain_a("t6_restart_written");
        tick(4);
        check("t6_frame_done", done_a, 6);

        // 6b: asynchronous reset mid-frame
        a_start();
        for (int i = 0; i < 4; i++) a_byte(8'(8'h5A + i), 1'b1, 0);
        wait_drain_a("t6_pre_reset_written");
        done_before = done_a;
        #2;
        rstb = 1'b0;
        #1;
        check("t6_rst_addr",  a_ram_address,  0);
        check("t6_rst_data",  a_ram_data_out, 0);
        check("t6_rst_busy",  a_busy,         0);
        check("t6_rst_we",    a_we,           0);
        @(negedge clk_in);
        rstb = 1'b1;
        tick(1);
        a_start();
        for (int i = 0; i < 16; i++) a_byte(8'($urandom_range(0, 255)), 1'b1, 0);
        wait_drain_a("t6_post_reset_written");
        tick(4);
        check("t6_post_reset_done", done_a, done_before + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
